backprop_sequencer: RTL
=======================

BACKPROP_SEQUENCER -- requirements
Module: backprop_sequencer

Interface
REQ-001 Parameter size, default 3: rows per layer matrix, equal to the stack's size.
REQ-002 Parameter max_layer_size, default 4: maximum layer count, equal to the stack's max_layer_size.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to run one backprop pass; sampled only in IDLE.
REQ-006 layer_count  input  32  number of layers in the pass; legal range 1..max_layer_size; sampled with start.
REQ-007 in_valid  input  1  upstream row (backprop_start/to_all/dense) present this cycle.
REQ-008 in_ready  output  1  sequencer consumes a row this cycle.
REQ-009 out_ready  output-side input  1  downstream accepts the dc_dw_stream word.
REQ-010 stream_valid  output  1  dc_dw_stream word is valid.
REQ-011 copy  output  1  drives the stack copy strobe.
REQ-012 cal_dy_dy_old  output  1  drives the stack propagate strobe.
REQ-013 stack_reset  output  1  drives the stack per-layer clear strobe; not the system reset.
REQ-014 current_layer_index  output  32  layer being processed.
REQ-015 dc_dw_layer_index  output  32  stream word index, 0..size-1.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at pass completion.
REQ-018 error  output  1  one-cycle pulse on rejected start.

Function
REQ-019 The FSM SHALL use states IDLE, LOAD, PROPAGATE, COPY, STREAM, CLEAR and DONE; all strobes are Moore decodes of the registered state.
REQ-020 IDLE: start with layer_count in 1..max_layer_size SHALL go to LOAD, set current_layer_index=layer_count-1 and row_cnt=0.
REQ-021 IDLE: start with layer_count 0 or >max_layer_size SHALL pulse error for the next cycle and stay in IDLE.
REQ-022 LOAD SHALL assert in_ready; each cycle with in_valid=1 increments row_cnt; in_valid=0 holds all state.
REQ-023 LOAD with in_valid=1 and row_cnt==size-1 SHALL go to PROPAGATE if current_layer_index>0, else to COPY.
REQ-024 PROPAGATE SHALL assert cal_dy_dy_old for exactly one cycle, then go to COPY.
REQ-025 COPY SHALL assert copy for exactly one cycle, clear dc_dw_layer_index to 0, then go to STREAM.
REQ-026 STREAM SHALL assert stream_valid; each cycle with out_ready=1 increments dc_dw_layer_index; out_ready=0 holds it.
REQ-027 STREAM with out_ready=1 and dc_dw_layer_index==size-1 SHALL go to CLEAR.
REQ-028 CLEAR SHALL assert stack_reset for one cycle. If current_layer_index==0 it goes to DONE; otherwise it decrements current_layer_index, clears row_cnt and goes to LOAD.
REQ-029 DONE SHALL pulse done for one cycle, then go to IDLE; current_layer_index stays 0.
REQ-030 start outside IDLE SHALL be ignored; strobes copy, cal_dy_dy_old, stack_reset, in_ready and stream_valid SHALL be mutually exclusive.
REQ-031 Index counters SHALL never wrap: current_layer_index never decrements below 0, and dc_dw_layer_index never exceeds size-1.

Reset
REQ-032 reset=1 at any clock edge, including mid-pass, SHALL force IDLE with row_cnt=0, current_layer_index=0 and dc_dw_layer_index=0.
REQ-033 While in reset and on the first cycle after reset, every 1-bit output SHALL be 0; reset takes priority over start.

Verification
REQ-034 layer_count=2, start at cycle 0, in_valid=out_ready=1 constantly -> LOAD 1-3, PROPAGATE 4, COPY 5, STREAM 6-8, CLEAR 9 (layer 1); LOAD 10-12, COPY 13, STREAM 14-16, CLEAR 17 (layer 0); done at 18; no cal_dy_dy_old for layer 0.
REQ-035 layer_count=0, then layer_count=5 -> error pulse each time, busy stays 0, no strobes asserted.
REQ-036 layer_count=1, in_valid low for 2 cycles after the first row -> LOAD lasts 5 cycles, in_ready high for all 5, COPY follows directly.
REQ-037 layer_count=1, out_ready=0 while dc_dw_layer_index==1 for 3 cycles -> stream_valid held, index held at 1, CLEAR one cycle after index 2 is accepted.
REQ-038 layer_count=4, reset asserted in STREAM of layer 2 -> next cycle IDLE, all outputs 0; a new start with layer_count=1 runs a clean 8-cycle pass with done on the 9th cycle.

Source files
------------

// File: rtl/backprop_sequencer_if.sv
// Handshake and status bundle between the backprop sequencer and its environment.
interface backprop_sequencer_if;
  logic        start;
  logic [31:0] layer_count;
  logic        in_valid;
  logic        in_ready;
  logic        out_ready;
  logic        stream_valid;
  logic        copy;
  logic        cal_dy_dy_old;
  logic        stack_reset;
  logic [31:0] current_layer_index;
  logic [31:0] dc_dw_layer_index;
  logic        busy;
  logic        done;
  logic        error;

  // Sequencer side.
  modport master (
    input  start, layer_count, in_valid, out_ready,
    output in_ready, stream_valid, copy, cal_dy_dy_old, stack_reset,
           current_layer_index, dc_dw_layer_index, busy, done, error
  );

  // Environment side: drives requests and rows, observes strobes.
  modport slave (
    output start, layer_count, in_valid, out_ready,
    input  in_ready, stream_valid, copy, cal_dy_dy_old, stack_reset,
           current_layer_index, dc_dw_layer_index, busy, done, error
  );
endinterface

// File: rtl/backprop_sequencer.sv
// Backprop pass sequencer: walks layers from top to bottom, loading rows,
// propagating, copying, streaming dc/dw words and clearing the stack per layer.
module backprop_sequencer #(
  parameter int size           = 3,
  parameter int max_layer_size = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  backprop_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, LOAD, PROPAGATE, COPY, STREAM, CLEAR, DONE
  } state_t;

  localparam logic [31:0] LAST_ROW = 32'(size - 1);
  localparam logic [31:0] MAX_LC   = 32'(max_layer_size);

  state_t      state_q, state_d;
  logic [31:0] row_cnt_q, row_cnt_d;
  logic [31:0] cli_q, cli_d;
  logic [31:0] dci_q, dci_d;
  logic        err_q, err_d;

  // State and counter registers; reset wins over any pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      cli_q     <= '0;
      dci_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      cli_q     <= cli_d;
      dci_q     <= dci_d;
      err_q     <= err_d;
    end
  end

  // Next-state and counter updates; counters saturate instead of wrapping.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    cli_d     = cli_q;
    dci_d     = dci_q;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.layer_count == 32'd0 || bus.layer_count > MAX_LC) begin
            err_d = 1'b1;
          end else begin
            state_d   = LOAD;
            cli_d     = bus.layer_count - 32'd1;
            row_cnt_d = '0;
          end
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          if (row_cnt_q == LAST_ROW) begin
            // Bottom layer has no older dy to propagate into.
            state_d = (cli_q != 32'd0) ? PROPAGATE : COPY;
          end else begin
            row_cnt_d = row_cnt_q + 32'd1;
          end
        end
      end
      PROPAGATE: state_d = COPY;
      COPY: begin
        dci_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (bus.out_ready) begin
          if (dci_q == LAST_ROW) state_d = CLEAR;
          else                   dci_d   = dci_q + 32'd1;
        end
      end
      CLEAR: begin
        if (cli_q == 32'd0) begin
          state_d = DONE;
        end else begin
          cli_d     = cli_q - 32'd1;
          row_cnt_d = '0;
          state_d   = LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore strobe decode from the registered state; one state -> one strobe.
  always_comb begin
    bus.in_ready            = (state_q == LOAD);
    bus.cal_dy_dy_old       = (state_q == PROPAGATE);
    bus.copy                = (state_q == COPY);
    bus.stream_valid        = (state_q == STREAM);
    bus.stack_reset         = (state_q == CLEAR);
    bus.done                = (state_q == DONE);
    bus.busy                = (state_q != IDLE);
    bus.error               = err_q;
    bus.current_layer_index = cli_q;
    bus.dc_dw_layer_index   = dci_q;
  end

endmodule
